// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port and the data-memory port. Data has fixed priority over fetch;
// a wait counter aborts an access that never sees memAck.
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT
// consecutive data grants with a fetch pending, the next grant goes to fetch.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clock,
  input  logic        reset,
  // instruction fetch port
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifRdata,
  output logic        ifReady,
  // data memory port
  input  logic        dmReq,
  input  logic        dmWe,
  input  logic [31:0] dmAddr,
  input  logic [31:0] dmWdata,
  output logic [31:0] dmRdata,
  output logic        dmReady,
  // shared memory
  output logic        memEn,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  // pipeline control
  output logic        arbPcWrite,
  output logic        arbIfIdWrite,
  output logic        arbMemStall,
  output logic        arbError
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
  localparam logic [31:0]   ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, FETCH = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] waitcnt, cnt_inc;
  logic          grant_d, grant_f, done, abort, fetch_first;

  assign cnt_inc = waitcnt + CW'(1);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [SW-1:0] starve_cnt;

  assign fetch_first = ifReq && (starve_cnt >= SW'(STARVE_LIMIT));

  // Count data grants made while a fetch is waiting; any fetch grant clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       starve_cnt <= '0;
    else if (grant_f) starve_cnt <= '0;
    else if (grant_d) starve_cnt <= ifReq ? starve_cnt + SW'(1) : '0;
  end
`else
  // Pure fixed priority: fetch only wins when no data request is present.
  assign fetch_first = ifReq && (STARVE_LIMIT < 0);
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus one-hot event strobes used by the datapath.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (ifReq && (fetch_first || !dmReq)) begin
          grant_f   = 1'b1;
          state_nxt = FETCH;
        end else if (dmReq) begin
          grant_d   = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA, FETCH: begin
        if (memAck)                done  = 1'b1;
        else if (cnt_inc == TO_VAL) abort = 1'b1;
        if (done || abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request registers, wait counter, completion data and ready pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memEn    <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dmRdata  <= '0;
      ifReady  <= 1'b0;
      dmReady  <= 1'b0;
      arbError <= 1'b0;
      waitcnt  <= '0;
    end else begin
      ifReady <= 1'b0;
      dmReady <= 1'b0;
      if (grant_d) begin
        memEn    <= 1'b1;
        memWe    <= dmWe;
        memAddr  <= dmAddr;
        memWdata <= dmWdata;
        waitcnt  <= '0;
      end
      if (grant_f) begin
        memEn   <= 1'b1;
        memWe   <= 1'b0;
        memAddr <= ifAddr;
        waitcnt <= '0;
      end
      if ((state != IDLE) && !done && !abort) waitcnt <= cnt_inc;
      if (done) begin
        memEn <= 1'b0;
        memWe <= 1'b0;
        if (state == DATA) begin
          // stores leave the last load data untouched
          if (!memWe) dmRdata <= memRdata;
          dmReady <= 1'b1;
        end else begin
          ifRdata <= memRdata;
          ifReady <= 1'b1;
        end
      end
      if (abort) begin
        memEn    <= 1'b0;
        memWe    <= 1'b0;
        arbError <= 1'b1;
        if (state == DATA) begin
          dmRdata <= ABORT_DATA;
          dmReady <= 1'b1;
        end else begin
          ifRdata <= ABORT_DATA;
          ifReady <= 1'b1;
        end
      end
    end
  end

  // Stall the front end while a fetch is outstanding, and MEM while a data access is.
  assign arbPcWrite   = !(ifReq && !ifReady);
  assign arbIfIdWrite = arbPcWrite;
  assign arbMemStall  = dmReq && !dmReady;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifReq, dmReq, dmWe, memAck;
  logic [31:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [31:0] ifRdata, dmRdata, memAddr, memWdata;
  logic        ifReady, dmReady, memEn, memWe;
  logic        arbPcWrite, arbIfIdWrite, arbMemStall, arbError;

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifReady(ifReady),
    .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmRdata(dmRdata), .dmReady(dmReady),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck),
    .arbPcWrite(arbPcWrite), .arbIfIdWrite(arbIfIdWrite),
    .arbMemStall(arbMemStall), .arbError(arbError)
  );

  always #5 clock = ~clock;

  // advance one cycle; outputs are settled and inputs may change on return
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ifReq = 0; dmReq = 0; dmWe = 0; memAck = 0;
    ifAddr = '0; dmAddr = '0; dmWdata = '0; memRdata = '0;
    tick(); tick();
    vecs++; if (memEn !== 1'b0) begin errs++; $display("FAIL rst_memEn got %b want 0", memEn); end
    vecs++; if (memWe !== 1'b0) begin errs++; $display("FAIL rst_memWe got %b want 0", memWe); end
    vecs++; if (memAddr !== 32'h0) begin errs++; $display("FAIL rst_memAddr got %h want 0", memAddr); end
    vecs++; if (dmRdata !== 32'h0 || ifRdata !== 32'h0) begin errs++; $display("FAIL rst_rdata got %h/%h want 0/0", dmRdata, ifRdata); end
    vecs++; if ({ifReady, dmReady, arbError} !== 3'b000) begin errs++; $display("FAIL rst_flags got %b want 000", {ifReady, dmReady, arbError}); end
    vecs++; if ({arbPcWrite, arbIfIdWrite, arbMemStall} !== 3'b110) begin errs++; $display("FAIL rst_stalls got %b want 110", {arbPcWrite, arbIfIdWrite, arbMemStall}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    ifReq = 1; ifAddr = 32'h40;
    #1;
    vecs++; if (arbPcWrite !== 1'b0) begin errs++; $display("FAIL fetch_pcw_req got %b want 0", arbPcWrite); end
    tick();
    vecs++; if (memEn !== 1'b1 || memAddr !== 32'h40 || memWe !== 1'b0) begin errs++; $display("FAIL fetch_grant got en=%b addr=%h we=%b want 1/40/0", memEn, memAddr, memWe); end
    vecs++; if (arbIfIdWrite !== 1'b0) begin errs++; $display("FAIL fetch_ifid_wait got %b want 0", arbIfIdWrite); end
    memAck = 1; memRdata = 32'h8C820004;
    tick();
    vecs++; if (ifReady !== 1'b1 || ifRdata !== 32'h8C820004) begin errs++; $display("FAIL fetch_done got rdy=%b data=%h want 1/8c820004", ifReady, ifRdata); end
    vecs++; if (memEn !== 1'b0 || arbPcWrite !== 1'b1) begin errs++; $display("FAIL fetch_release got en=%b pcw=%b want 0/1", memEn, arbPcWrite); end
    memAck = 0; ifReq = 0;
    tick();
    vecs++; if (ifReady !== 1'b0 || memEn !== 1'b0) begin errs++; $display("FAIL fetch_pulse_width got rdy=%b en=%b want 0/0", ifReady, memEn); end
  endtask

  task automatic test_priority();
    dmReq = 1; dmWe = 0; dmAddr = 32'h200; ifReq = 1; ifAddr = 32'h80;
    tick();
    vecs++; if (memEn !== 1'b1 || memAddr !== 32'h200) begin errs++; $display("FAIL prio_data_first got en=%b addr=%h want 1/200", memEn, memAddr); end
    vecs++; if (arbMemStall !== 1'b1) begin errs++; $display("FAIL prio_memstall got %b want 1", arbMemStall); end
    memAck = 1; memRdata = 32'hA5A50001;
    tick();
    vecs++; if (dmReady !== 1'b1 || dmRdata !== 32'hA5A50001 || arbMemStall !== 1'b0) begin errs++; $display("FAIL prio_data_done got rdy=%b data=%h stall=%b want 1/a5a50001/0", dmReady, dmRdata, arbMemStall); end
    vecs++; if (memEn !== 1'b0) begin errs++; $display("FAIL prio_bubble got en=%b want 0", memEn); end
    dmReq = 0; memAck = 0;
    tick();
    vecs++; if (memEn !== 1'b1 || memAddr !== 32'h80) begin errs++; $display("FAIL prio_fetch_next got en=%b addr=%h want 1/80", memEn, memAddr); end
    memAck = 1; memRdata = 32'h11112222;
    tick();
    vecs++; if (ifReady !== 1'b1 || ifRdata !== 32'h11112222) begin errs++; $display("FAIL prio_fetch_done got rdy=%b data=%h want 1/11112222", ifReady, ifRdata); end
    ifReq = 0; memAck = 0;
    tick();
  endtask

  task automatic test_store();
    dmReq = 1; dmWe = 1; dmAddr = 32'h100; dmWdata = 32'h12345678;
    tick();
    vecs++; if ({memEn, memWe} !== 2'b11 || memAddr !== 32'h100 || memWdata !== 32'h12345678) begin errs++; $display("FAIL store_grant got en/we=%b addr=%h wd=%h want 11/100/12345678", {memEn, memWe}, memAddr, memWdata); end
    dmWe = 0; dmAddr = 32'hFFF; dmWdata = 32'h0;
    tick();
    vecs++; if ({memEn, memWe} !== 2'b11 || memAddr !== 32'h100 || memWdata !== 32'h12345678) begin errs++; $display("FAIL store_hold got en/we=%b addr=%h wd=%h want 11/100/12345678", {memEn, memWe}, memAddr, memWdata); end
    memAck = 1; memRdata = 32'hBAD0BAD0;
    tick();
    vecs++; if (dmReady !== 1'b1 || dmRdata !== 32'hA5A50001) begin errs++; $display("FAIL store_done got rdy=%b data=%h want 1/a5a50001", dmReady, dmRdata); end
    dmReq = 0; memAck = 0;
    tick();
  endtask

  task automatic test_idle_ack();
    memAck = 1; memRdata = 32'h0BADF00D;
    tick();
    vecs++; if ({ifReady, dmReady, memEn} !== 3'b000 || dmRdata !== 32'hA5A50001 || ifRdata !== 32'h11112222) begin errs++; $display("FAIL idle_ack got flags=%b dm=%h if=%h want 000/a5a50001/11112222", {ifReady, dmReady, memEn}, dmRdata, ifRdata); end
    memAck = 0;
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    dmReq = 1; dmWe = 0; dmAddr = 32'h300;
    tick();
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (dmReady !== 1'b0 || memEn !== 1'b1 || arbError !== 1'b0) early++;
    end
    vecs++; if (early != 0) begin errs++; $display("FAIL timeout_early got %0d bad cycles want 0", early); end
    tick();
    vecs++; if (dmReady !== 1'b1 || dmRdata !== 32'hDEADBEEF) begin errs++; $display("FAIL timeout_abort got rdy=%b data=%h want 1/deadbeef", dmReady, dmRdata); end
    vecs++; if (arbError !== 1'b1 || memEn !== 1'b0) begin errs++; $display("FAIL timeout_flag got err=%b en=%b want 1/0", arbError, memEn); end
    dmReq = 0;
    tick(); tick();
    vecs++; if (arbError !== 1'b1 || dmReady !== 1'b0) begin errs++; $display("FAIL timeout_sticky got err=%b rdy=%b want 1/0", arbError, dmReady); end
  endtask

  task automatic test_reset_mid_fetch();
    int pulses;
    pulses = 0;
    ifReq = 1; ifAddr = 32'h500;
    tick();
    vecs++; if (memEn !== 1'b1 || memAddr !== 32'h500) begin errs++; $display("FAIL rstmid_grant got en=%b addr=%h want 1/500", memEn, memAddr); end
    #2 reset = 1'b0; memAck = 1; memRdata = 32'h77777777;
    #1;
    vecs++; if (memEn !== 1'b0 || memAddr !== 32'h0 || arbError !== 1'b0) begin errs++; $display("FAIL rstmid_async got en=%b addr=%h err=%b want 0/0/0", memEn, memAddr, arbError); end
    tick();
    if (ifReady !== 1'b0) pulses++;
    reset = 1'b1; ifReq = 0;
    tick();
    if (ifReady !== 1'b0) pulses++;
    tick();
    if (ifReady !== 1'b0) pulses++;
    vecs++; if (pulses != 0 || ifRdata !== 32'h0 || memEn !== 1'b0) begin errs++; $display("FAIL rstmid_idle got pulses=%0d data=%h en=%b want 0/0/0", pulses, ifRdata, memEn); end
    memAck = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    string got, want;
    got = "";
`ifdef MEM_ARB_STARVE_GUARD_EN
    want = "DDDDFD";
`else
    want = "DDDDDD";
`endif
    dmReq = 1; dmWe = 0; dmAddr = 32'h600; ifReq = 1; ifAddr = 32'h700;
    memAck = 1; memRdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (memEn === 1'b1) got = {got, (memAddr == 32'h700) ? "F" : "D"};
    end
    vecs++; if (got != want) begin errs++; $display("FAIL b2b_order got %s want %s", got, want); end
    dmReq = 0; ifReq = 0; memAck = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_idle_ack();
    test_timeout();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning memAck wait limit in cycles before abort.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive data grants allowed while a fetch waits (used only under REQ-024).
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ifReq, ifAddr  in  1, 32  instruction-fetch request and word address.
REQ-006 ifRdata, ifReady  out  32, 1  fetched word; one-cycle completion pulse.
REQ-007 dmReq, dmWe, dmAddr, dmWdata  in  1, 1, 32, 32  data-memory request, write enable, address, write data.
REQ-008 dmRdata, dmReady  out  32, 1  load data; one-cycle completion pulse.
REQ-009 memEn, memWe, memAddr, memWdata  out  1, 1, 32, 32  shared single-port memory request.
REQ-010 memRdata, memAck  in  32, 1  memory read data; access-complete strobe.
REQ-011 arbPcWrite, arbIfIdWrite, arbMemStall, arbError  out  1 each  PC/IF-ID write enables, MEM-stage stall, sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, DATA, FETCH; reset state IDLE.
REQ-013 IDLE: dmReq -> DATA; else ifReq -> FETCH; else stay.
REQ-014 Simultaneous dmReq and ifReq in IDLE SHALL grant DATA (fixed priority) unless REQ-024 overrides.
REQ-015 On grant, SHALL register requester's address/data/we onto mem* and assert memEn from the next cycle, held stable until memAck.
REQ-016 In DATA/FETCH, memAck high SHALL capture memRdata into dmRdata/ifRdata (write: dmRdata unchanged), pulse dmReady/ifReady for exactly one cycle next edge, deassert memEn, return to IDLE.
REQ-017 Minimum latency: request sampled edge N, memEn high cycle N+1, memAck in N+1 -> ready pulse cycle N+2; one IDLE bubble between back-to-back grants.
REQ-018 memAck in IDLE SHALL be ignored.
REQ-019 A 4-bit-or-wider wait counter SHALL clear on grant and increment each DATA/FETCH cycle without memAck; reaching TIMEOUT_CYCLES SHALL set arbError, pulse the owner's ready with rdata 32'hDEADBEEF, drop memEn, return to IDLE.
REQ-020 arbError SHALL stay set until reset.
REQ-021 Combinational stalls: arbPcWrite = arbIfIdWrite = !(ifReq && !ifReady); arbMemStall = dmReq && !dmReady.
REQ-022 Requester inputs changing while its access is in flight SHALL NOT alter mem* outputs.

Reset
REQ-023 reset low SHALL immediately force IDLE, memEn/memWe/ifReady/dmReady/arbError 0, memAddr/memWdata/ifRdata/dmRdata 0, counters 0, aborting any in-flight access without a ready pulse.

Configuration
REQ-024 Macro MEM_ARB_STARVE_GUARD_EN defined: count consecutive DATA grants while ifReq pending; at STARVE_LIMIT the next IDLE grant SHALL go to FETCH and the count clears (also clears on any FETCH grant); undefined: pure fixed priority per REQ-014, no counter.

Verification
REQ-025 Lone ifReq, ifAddr=0x40, memAck one cycle after memEn, memRdata=0x8C820004 -> ifReady pulse, ifRdata=0x8C820004, arbPcWrite low until pulse.
REQ-026 dmReq+ifReq same edge -> DATA first (memAddr=dmAddr), FETCH after one IDLE bubble.
REQ-027 Store dmWe=1, dmAddr=0x100, dmWdata=0x12345678 -> memWe=1, memWdata=0x12345678 held until memAck; dmReady pulse, dmRdata unchanged.
REQ-028 memAck never asserted -> after 15 wait cycles dmReady pulse, dmRdata=0xDEADBEEF, arbError=1 until reset.
REQ-029 reset low mid-FETCH -> memEn 0 asynchronously, no ifReady pulse, FSM IDLE.
REQ-030 With MEM_ARB_STARVE_GUARD_EN, continuous dmReq+ifReq -> grant order D,D,D,D,F,D...; without it, F never granted.
